lsu_rv32: RTL and testbench



---
 rtl/lsu_rv32.sv | 178 +++++++++++++++++
 tb/tb_lsu_rv32.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_rv32.sv
// RV32I load/store unit: byte-lane steering for stores, lane extraction and
// sign/zero extension for loads, behind a req/ready word-addressed memory port.
module lsu_rv32 #(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic             req_we,
  input  logic [2:0]       req_funct3,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] wdata,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] rdata,
  output logic             misaligned,
  output logic             access_fault,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [3:0]       mem_wstrb,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_ready,
  input  logic [WIDTH-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, BUSY, DONE, EXC} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             we_q;
  logic [2:0]       funct3_q;
  logic [1:0]       off_q;

  logic             done_q, misaligned_q, access_fault_q;
  logic             mem_req_q, mem_we_q;
  logic [WIDTH-1:0] mem_addr_q, mem_wdata_q, rdata_q;
  logic [3:0]       mem_wstrb_q;

  logic             illegal;
  logic [3:0]       st_strb;
  logic [WIDTH-1:0] st_wdata;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [WIDTH-1:0] ld_data;

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and infers a latch.
  always_comb begin
    illegal = 1'b0;
    case (req_funct3)
      F3_B, F3_BU: illegal = 1'b0;
      F3_H, F3_HU: illegal = addr[0];
      F3_W:        illegal = |addr[1:0];
      default:     illegal = 1'b1;
    endcase
    if (req_we && req_funct3[2]) illegal = 1'b1;
  end

  always_comb begin
    st_strb  = 4'b1111;
    st_wdata = wdata;
    case (req_funct3[1:0])
      2'b00: begin
        st_strb  = 4'b0001 << addr[1:0];
        st_wdata = {4{wdata[7:0]}};
      end
      2'b01: begin
        st_strb  = 4'b0011 << {addr[1], 1'b0};
        st_wdata = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign ld_byte = mem_rdata[{off_q, 3'b000} +: 8];
  assign ld_half = mem_rdata[{off_q[1], 4'b0000} +: 16];

  always_comb begin
    ld_data = mem_rdata;
    case (funct3_q)
      F3_B:    ld_data = {{(WIDTH-8){ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data = {{(WIDTH-8){1'b0}}, ld_byte};
      F3_H:    ld_data = {{(WIDTH-16){ld_half[15]}}, ld_half};
      F3_HU:   ld_data = {{(WIDTH-16){1'b0}}, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: all control and output registers reset so no spurious request or pulse leaves reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      we_q           <= 1'b0;
      funct3_q       <= 3'b000;
      off_q          <= 2'b00;
      done_q         <= 1'b0;
      misaligned_q   <= 1'b0;
      access_fault_q <= 1'b0;
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wstrb_q    <= 4'b0000;
      mem_wdata_q    <= '0;
      rdata_q        <= '0;
    end else begin
      done_q         <= 1'b0;
      misaligned_q   <= 1'b0;
      access_fault_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            if (illegal) begin
              state_q      <= EXC;
              misaligned_q <= 1'b1;
            end else begin
              state_q     <= BUSY;
              cnt_q       <= '0;
              we_q        <= req_we;
              funct3_q    <= req_funct3;
              off_q       <= addr[1:0];
              mem_req_q   <= 1'b1;
              mem_we_q    <= req_we;
              mem_addr_q  <= {addr[WIDTH-1:2], 2'b00};
              mem_wstrb_q <= req_we ? st_strb : 4'b0000;
              mem_wdata_q <= st_wdata;
            end
          end
        end
        BUSY: begin
          cnt_q <= cnt_q + 1'b1;
          // Ready wins over timeout when both land in the last allowed cycle.
          if (mem_ready) begin
            state_q     <= DONE;
            done_q      <= 1'b1;
            rdata_q     <= we_q ? '0 : ld_data;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wstrb_q <= 4'b0000;
          end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_q        <= EXC;
            access_fault_q <= 1'b1;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_wstrb_q    <= 4'b0000;
          end
        end
        DONE:    state_q <= IDLE;
        EXC:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // The core must freeze in the same cycle it presents a load/store.
  assign stall = (state_q == IDLE) ? req_valid : (state_q == BUSY);

  assign done         = done_q;
  assign rdata        = rdata_q;
  assign misaligned   = misaligned_q;
  assign access_fault = access_fault_q;
  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wstrb    = mem_wstrb_q;
  assign mem_wdata    = mem_wdata_q;

endmodule

// File: tb/tb_lsu_rv32.sv
// Bench for lsu_rv32: directed vector table, random accesses against a reference
// model, and hand sequences for timeout and reset during an access.
module tb_lsu_rv32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel_t = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, mem_ready = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] addr = '0, wdata = '0, mem_rdata = '0;

  logic        stall_m, done_m, mis_m, af_m, mreq_m, mwe_m;
  logic [31:0] rdata_m, maddr_m, mwdata_m;
  logic [3:0]  mwstrb_m;
  logic        stall_t, done_t, mis_t, af_t, mreq_t, mwe_t;
  logic [31:0] rdata_t, maddr_t, mwdata_t;
  logic [3:0]  mwstrb_t;

  logic        stall, done, misaligned, access_fault, mem_req, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;

  int n_vec = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  lsu_rv32 #(.WIDTH(32), .TIMEOUT_CYCLES(255)) dut_m (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid & ~sel_t), .req_we(req_we),
    .req_funct3(req_funct3), .addr(addr), .wdata(wdata), .stall(stall_m),
    .done(done_m), .rdata(rdata_m), .misaligned(mis_m), .access_fault(af_m),
    .mem_req(mreq_m), .mem_we(mwe_m), .mem_addr(maddr_m), .mem_wstrb(mwstrb_m),
    .mem_wdata(mwdata_m), .mem_ready(mem_ready & ~sel_t), .mem_rdata(mem_rdata));

  lsu_rv32 #(.WIDTH(32), .TIMEOUT_CYCLES(4)) dut_t (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid & sel_t), .req_we(req_we),
    .req_funct3(req_funct3), .addr(addr), .wdata(wdata), .stall(stall_t),
    .done(done_t), .rdata(rdata_t), .misaligned(mis_t), .access_fault(af_t),
    .mem_req(mreq_t), .mem_we(mwe_t), .mem_addr(maddr_t), .mem_wstrb(mwstrb_t),
    .mem_wdata(mwdata_t), .mem_ready(mem_ready & sel_t), .mem_rdata(mem_rdata));

  assign stall        = sel_t ? stall_t  : stall_m;
  assign done         = sel_t ? done_t   : done_m;
  assign misaligned   = sel_t ? mis_t    : mis_m;
  assign access_fault = sel_t ? af_t     : af_m;
  assign mem_req      = sel_t ? mreq_t   : mreq_m;
  assign mem_we       = sel_t ? mwe_t    : mwe_m;
  assign rdata        = sel_t ? rdata_t  : rdata_m;
  assign mem_addr     = sel_t ? maddr_t  : maddr_m;
  assign mem_wdata    = sel_t ? mwdata_t : mwdata_m;
  assign mem_wstrb    = sel_t ? mwstrb_t : mwstrb_m;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    int          delay;
    logic        mis;
    logic [3:0]  strb;
    logic [31:0] wd_exp;
    logic [31:0] rd_exp;
  } vec_t;

  vec_t tbl[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: derived from access size/offset arithmetic, not lane muxes.
  function automatic vec_t model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [31:0] rd, input int delay);
    vec_t v;
    int size, off;
    logic [31:0] mask, val;
    off  = int'(a % 4);
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : (f3[1:0] == 2'd2) ? 4 : 0;
    v.we = we; v.f3 = f3; v.addr = a; v.wdata = wd; v.rd = rd; v.delay = delay;
    v.mis = (size == 0) || (f3 == 3'b110) || (we && f3 >= 3'd4) || (int'(a % 32'(size)) != 0);
    v.strb = we ? 4'(((1 << size) - 1) << off) : 4'h0;
    if (size == 1)      v.wd_exp = (wd & 32'hFF) * 32'h0101_0101;
    else if (size == 2) v.wd_exp = (wd & 32'hFFFF) * 32'h0001_0001;
    else                v.wd_exp = wd;
    if (we || v.mis) v.rd_exp = 32'h0;
    else if (size == 4) v.rd_exp = rd;
    else begin
      mask = (32'h1 << (8 * size)) - 1;
      val  = (rd >> (8 * off)) & mask;
      if (f3 < 3'd4 && val[8*size-1]) val = val | ~mask;
      v.rd_exp = val;
    end
    return v;
  endfunction

  task automatic do_access(input vec_t v);
    logic [31:0] a_exp;
    a_exp = v.addr & 32'hFFFF_FFFC;
    @(negedge clk);
    req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3; addr = v.addr; wdata = v.wdata;
    mem_ready = 1'b0; mem_rdata = $urandom;
    #1;
    check("stall_accept", stall, 1);
    check("mem_req_idle", mem_req, 0);
    @(posedge clk); #1;
    if (v.mis) begin
      check("misaligned_pulse", misaligned, 1);
      check("fault_on_misalign", access_fault, 0);
      check("stall_exc", stall, 0);
      check("mem_req_exc", mem_req, 0);
      check("done_exc", done, 0);
      @(negedge clk); req_valid = 1'b0;
      @(posedge clk); #1;
      check("misaligned_clear", misaligned, 0);
      check("mem_req_after_exc", mem_req, 0);
    end else begin
      for (int k = 0; k <= v.delay; k++) begin
        check("mem_req_busy", mem_req, 1);
        check("stall_busy", stall, 1);
        check("done_busy", done, 0);
        check("mem_addr", mem_addr, a_exp);
        check("mem_we", mem_we, v.we);
        check("mem_wstrb", mem_wstrb, v.strb);
        if (v.we) check("mem_wdata", mem_wdata, v.wd_exp);
        @(negedge clk);
        mem_ready = (k == v.delay);
        mem_rdata = (k == v.delay) ? v.rd : $urandom;
        @(posedge clk); #1;
      end
      check("done_pulse", done, 1);
      check("stall_done", stall, 0);
      check("mem_req_done", mem_req, 0);
      check("fault_done", access_fault, 0);
      check("rdata", rdata, v.rd_exp);
      @(negedge clk); req_valid = 1'b0; mem_ready = 1'b0;
      @(posedge clk); #1;
      check("done_clear", done, 0);
      check("stall_idle", stall, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    tbl[0]  = '{1'b0, 3'b000, 32'h1003, 32'h0,        32'h8000_0000, 0, 1'b0, 4'h0, 32'h0,        32'hFFFF_FF80};
    tbl[1]  = '{1'b0, 3'b100, 32'h1003, 32'h0,        32'h8000_0000, 0, 1'b0, 4'h0, 32'h0,        32'h0000_0080};
    tbl[2]  = '{1'b1, 3'b001, 32'h2002, 32'hDEAD_BEEF, 32'h0,        0, 1'b0, 4'hC, 32'hBEEF_BEEF, 32'h0};
    tbl[3]  = '{1'b0, 3'b010, 32'h3001, 32'h0,        32'h0,         0, 1'b1, 4'h0, 32'h0,        32'h0};
    tbl[4]  = '{1'b1, 3'b100, 32'h0010, 32'h1234_5678, 32'h0,        0, 1'b1, 4'h0, 32'h0,        32'h0};
    tbl[5]  = '{1'b0, 3'b101, 32'h4002, 32'h0,        32'h8001_1234, 5, 1'b0, 4'h0, 32'h0,        32'h0000_8001};
    tbl[6]  = '{1'b0, 3'b001, 32'h4000, 32'h0,        32'h1234_F00D, 1, 1'b0, 4'h0, 32'h0,        32'hFFFF_F00D};
    tbl[7]  = '{1'b1, 3'b000, 32'h5001, 32'h0000_00A5, 32'h0,        2, 1'b0, 4'h2, 32'hA5A5_A5A5, 32'h0};
    tbl[8]  = '{1'b1, 3'b010, 32'h6000, 32'h1234_5678, 32'h0,        0, 1'b0, 4'hF, 32'h1234_5678, 32'h0};
    tbl[9]  = '{1'b0, 3'b010, 32'h7000, 32'h0,        32'hCAFE_BABE, 2, 1'b0, 4'h0, 32'h0,        32'hCAFE_BABE};
    tbl[10] = '{1'b0, 3'b011, 32'h8000, 32'h0,        32'h0,         0, 1'b1, 4'h0, 32'h0,        32'h0};
    tbl[11] = '{1'b0, 3'b001, 32'h8001, 32'h0,        32'h0,         0, 1'b1, 4'h0, 32'h0,        32'h0};
    tbl[12] = '{1'b1, 3'b111, 32'h8000, 32'h0,        32'h0,         0, 1'b1, 4'h0, 32'h0,        32'h0};
    tbl[13] = '{1'b1, 3'b001, 32'h2003, 32'h0,        32'h0,         0, 1'b1, 4'h0, 32'h0,        32'h0};
    tbl[14] = '{1'b0, 3'b000, 32'h9001, 32'h0,        32'h0000_7F00, 0, 1'b0, 4'h0, 32'h0,        32'h0000_007F};

    // Reset state, with req_valid high to show stall tracks it in IDLE.
    req_valid = 1'b1;
    #12;
    check("rst_stall", stall, 1);
    check("rst_done", done, 0);
    check("rst_mis", misaligned, 0);
    check("rst_fault", access_fault, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_wstrb", mem_wstrb, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_rdata", rdata, 0);
    req_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;

    foreach (tbl[i]) do_access(tbl[i]);

    for (int i = 0; i < 200; i++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a = a & 32'hFFFF_FFFC;
      v = model(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, $urandom,
                int'($urandom_range(0, 4)));
      do_access(v);
    end

    // Timeout on the 4-cycle instance: ready never comes.
    @(negedge clk);
    sel_t = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; addr = 32'h20; mem_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); req_valid = 1'b0;
    #1;
    for (int b = 0; b < 4; b++) begin
      check("to_mem_req", mem_req, 1);
      check("to_stall", stall, 1);
      check("to_fault_early", access_fault, 0);
      check("to_addr", mem_addr, 32'h20);
      @(posedge clk); #1;
    end
    check("to_fault_pulse", access_fault, 1);
    check("to_mem_req_drop", mem_req, 0);
    check("to_stall_exc", stall, 0);
    check("to_done", done, 0);
    check("to_mis", misaligned, 0);
    @(posedge clk); #1;
    check("to_fault_clear", access_fault, 0);
    check("to_idle_req", mem_req, 0);
    // Ready in the final allowed BUSY cycle still completes.
    v = '{1'b0, 3'b010, 32'h24, 32'h0, 32'hA5A5_0F0F, 3, 1'b0, 4'h0, 32'h0, 32'hA5A5_0F0F};
    do_access(v);
    @(negedge clk); sel_t = 1'b0;

    // Asynchronous reset in the middle of a store.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; addr = 32'h100; wdata = 32'h0BAD_F00D;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    check("rb_mem_req", mem_req, 1);
    #2;
    rst_n = 1'b0; req_valid = 1'b0;
    #1;
    check("rb_mem_req_drop", mem_req, 0);
    check("rb_stall_drop", stall, 0);
    check("rb_mem_we", mem_we, 0);
    check("rb_wstrb", mem_wstrb, 0);
    check("rb_done", done, 0);
    @(posedge clk); #1;
    check("rb_done_held", done, 0);
    @(negedge clk); rst_n = 1'b1;
    v = '{1'b0, 3'b010, 32'h0, 32'h0, 32'h1357_9BDF, 0, 1'b0, 4'h0, 32'h0, 32'h1357_9BDF};
    do_access(v);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
